// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the datapath run/halt/step sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dp_ctrl_pkg;

  // Sequencer states; the values are visible on state_o for debug.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RSTDP = 3'd1,
    RUN   = 3'd2,
    STEP  = 3'd3,
    HALT  = 3'd4
  } state_e;

  // Reasons the sequencer stopped the datapath.
  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EXT     = 3'd1;
  localparam logic [2:0] CAUSE_LOOP    = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  // Bits needed to hold values 0..n (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dp_loop_detect.sv
// Branch-to-self detector: counts consecutive committed cycles with pc_next == pc.
// Latency: loop_hit_o is combinational in the cycle that reaches LOOP_LIMIT.
// Backpressure: none; counter only moves when en_i is high, clr_i wins.
module dp_loop_detect
  import dp_ctrl_pkg::*;
#(
  parameter int LOOP_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_next_i,
  output logic        loop_hit_o
);

  localparam int LW = cnt_bits(LOOP_LIMIT);
  localparam logic [LW-1:0] LIMIT_V  = LW'(LOOP_LIMIT);
  localparam logic [LW:0]   LIMIT_V1 = (LW+1)'(LOOP_LIMIT);

  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW:0]   cnt_inc;
  logic          self_br;

  assign self_br    = (pc_next_i == pc_i);
  assign cnt_inc    = {1'b0, cnt_q} + (LW+1)'(1);
  // The commit that makes the run LOOP_LIMIT long is the one that fires.
  assign loop_hit_o = en_i && self_br && (cnt_inc == LIMIT_V1);

  // Next run length: clear wins, otherwise grow on self-branch commits and
  // drop to zero on any other commit; hold when the datapath is stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (!self_br)
        cnt_d = '0;
      else if (cnt_q != LIMIT_V)
        cnt_d = cnt_inc[LW-1:0];
    end
  end

  // Run-length register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/datapath_run_ctrl.sv
// Run/halt/single-step sequencer owning the datapath reset and advance enable.
// Latency: Moore outputs, one cycle from a control pulse to the new state.
// Backpressure: none; halt_req blocks step/resume, start always wins.
module datapath_run_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int LOOP_LIMIT = 4,
  parameter int MAX_CYCLES = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             resume,
  input  logic             halt_req,
  input  logic [31:0]      pc,
  input  logic [31:0]      pc_next,
  input  logic             branchfinal,
  output logic             dp_rst,
  output logic             dp_en,
  output logic             halted,
  output logic             busy,
  output logic [2:0]       halt_cause,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] branch_count
);

  localparam int HW = cnt_bits(RST_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CNT_W:0] MAX_V     = (CNT_W+1)'(MAX_CYCLES);

  state_e           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] branch_q, branch_d;
  logic             loop_hit;
  logic             tmo_hit;
  logic             loop_clr;

  // Moore decode of the registered state.
  assign dp_rst       = (state_q == RSTDP);
  assign dp_en        = (state_q == RUN) || (state_q == STEP);
  assign halted       = (state_q == HALT);
  assign busy         = (state_q == RSTDP) || (state_q == RUN) || (state_q == STEP);
  assign halt_cause   = cause_q;
  assign state_o      = state_q;
  assign cycle_count  = cycle_q;
  assign branch_count = branch_q;

  // Timeout fires on the commit that brings the cycle count to MAX_CYCLES.
  assign tmo_hit  = (MAX_CYCLES != 0) && dp_en &&
                    (({1'b0, cycle_q} + (CNT_W+1)'(1)) == MAX_V);
  // A fresh run starts with no loop history: on (re)start and on leaving HALT.
  assign loop_clr = start || ((state_q == HALT) && (state_d != HALT));

  dp_loop_detect #(
    .LOOP_LIMIT (LOOP_LIMIT)
  ) u_loop_detect (
    .clk        (clk),
    .rst        (rst),
    .en_i       (dp_en),
    .clr_i      (loop_clr),
    .pc_i       (pc),
    .pc_next_i  (pc_next),
    .loop_hit_o (loop_hit)
  );

  // Next-state, hold counter and halt cause; start outranks everything.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hold_d  = hold_q;
    if (start) begin
      state_d = RSTDP;
      hold_d  = '0;
      cause_d = CAUSE_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt_req && step) state_d = STEP;
        end
        RSTDP: begin
          if (hold_q == HOLD_LAST) state_d = RUN;
          else                     hold_d  = hold_q + 1'b1;
        end
        RUN: begin
          if (halt_req) begin
            state_d = HALT;
            cause_d = CAUSE_EXT;
          end else if (loop_hit) begin
            state_d = HALT;
            cause_d = CAUSE_LOOP;
          end else if (tmo_hit) begin
            state_d = HALT;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        STEP: begin
          state_d = HALT;
          if (loop_hit)     cause_d = CAUSE_LOOP;
          else if (tmo_hit) cause_d = CAUSE_TIMEOUT;
          else              cause_d = CAUSE_STEP;
        end
        HALT: begin
          if (!halt_req) begin
            if (step) begin
              state_d = STEP;
              cause_d = CAUSE_NONE;
            end else if (resume) begin
              state_d = RUN;
              cause_d = CAUSE_NONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cause_d = CAUSE_NONE;
        end
      endcase
    end
  end

  // Event counters: cleared on (re)start, saturating increments on commits.
  always_comb begin
    cycle_d  = cycle_q;
    branch_d = branch_q;
    if (start) begin
      cycle_d  = '0;
      branch_d = '0;
    end else if (dp_en) begin
      if (cycle_q != '1)                  cycle_d  = cycle_q + 1'b1;
      if (branchfinal && branch_q != '1) branch_d = branch_q + 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cause_q  <= CAUSE_NONE;
      hold_q   <= '0;
      cycle_q  <= '0;
      branch_q <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      hold_q   <= hold_d;
      cycle_q  <= cycle_d;
      branch_q <= branch_d;
    end
  end

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Self-checking bench for datapath_run_ctrl: directed scenarios plus random run.
// Latency: inputs applied before an edge, outputs sampled 1 time unit after it.
// Backpressure: n/a.
module tb_datapath_run_ctrl;

  localparam int RSTC  = 2;
  localparam int LOOPL = 4;
  localparam int MAXC  = 10;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0, start = 1'b0, step = 1'b0, resume = 1'b0, halt_req = 1'b0;
  logic [31:0]   pc = '0, pc_next = '0;
  logic          branchfinal = 1'b0;
  logic          dp_rst, dp_en, halted, busy;
  logic [2:0]    halt_cause, state_o;
  logic [CW-1:0] cycle_count, branch_count;

  int ncmp = 0;
  int nerr = 0;
  bit loop_pcs = 1'b0;

  // Reference model: mode 0 idle,1 datapath reset,2 running,3 single step,4 halted.
  int m_state = 0, m_hold = 0, m_cyc = 0, m_br = 0, m_run = 0, m_cause = 0;

  datapath_run_ctrl #(
    .RST_CYCLES (RSTC),
    .LOOP_LIMIT (LOOPL),
    .MAX_CYCLES (MAXC),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .step         (step),
    .resume       (resume),
    .halt_req     (halt_req),
    .pc           (pc),
    .pc_next      (pc_next),
    .branchfinal  (branchfinal),
    .dp_rst       (dp_rst),
    .dp_en        (dp_en),
    .halted       (halted),
    .busy         (busy),
    .halt_cause   (halt_cause),
    .state_o      (state_o),
    .cycle_count  (cycle_count),
    .branch_count (branch_count)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit en, self_br, loop_hit, tmo;
    int nrun;
    if (rst) begin
      m_state = 0; m_hold = 0; m_cyc = 0; m_br = 0; m_run = 0; m_cause = 0;
      return;
    end
    en       = (m_state == 2) || (m_state == 3);
    self_br  = en && (pc == pc_next);
    nrun     = !en ? m_run : (self_br ? m_run + 1 : 0);
    loop_hit = self_br && (nrun == LOOPL);
    tmo      = en && (MAXC != 0) && (m_cyc + 1 == MAXC);
    if (en) begin
      if (m_cyc < CMAX) m_cyc++;
      if (branchfinal && m_br < CMAX) m_br++;
    end
    m_run = nrun;
    if (start) begin
      m_state = 1; m_hold = RSTC; m_cyc = 0; m_br = 0; m_run = 0; m_cause = 0;
    end else begin
      case (m_state)
        0: if (!halt_req && step) m_state = 3;
        1: begin m_hold--; if (m_hold == 0) m_state = 2; end
        2: begin
          if (halt_req)      begin m_state = 4; m_cause = 1; end
          else if (loop_hit) begin m_state = 4; m_cause = 2; end
          else if (tmo)      begin m_state = 4; m_cause = 3; end
        end
        3: begin
          m_state = 4;
          m_cause = loop_hit ? 2 : (tmo ? 3 : 4);
        end
        default: begin
          if (!halt_req && (step || resume)) begin
            m_state = step ? 3 : 2; m_run = 0; m_cause = 0;
          end
        end
      endcase
    end
  endtask

  // One clock: choose datapath PCs, advance the model, let the edge happen.
  task automatic tick();
    if (loop_pcs) begin pc = 32'h14; pc_next = 32'h14; end
    else begin pc = $urandom; pc_next = pc + 32'd4; end
    branchfinal = 1'($urandom_range(0, 1));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    ncmp++; if (state_o !== 3'd0) begin nerr++; $display("FAIL reset_state: got %0d want 0", state_o); end
    ncmp++; if ({dp_rst, dp_en, halted, busy} !== 4'b0) begin nerr++; $display("FAIL reset_flags: got %b want 0000", {dp_rst, dp_en, halted, busy}); end
    ncmp++; if (halt_cause !== 3'd0) begin nerr++; $display("FAIL reset_cause: got %0d want 0", halt_cause); end
    ncmp++; if ({cycle_count, branch_count} !== '0) begin nerr++; $display("FAIL reset_counts: got %0d/%0d want 0/0", cycle_count, branch_count); end
  endtask

  task automatic test_start_run();
    loop_pcs = 1'b0;
    do_start();
    ncmp++; if (dp_rst !== 1'b1 || state_o !== 3'd1) begin nerr++; $display("FAIL rst_hold1: dp_rst=%b state=%0d want 1/1", dp_rst, state_o); end
    tick();
    ncmp++; if (dp_rst !== 1'b1 || dp_en !== 1'b0) begin nerr++; $display("FAIL rst_hold2: dp_rst=%b dp_en=%b want 1/0", dp_rst, dp_en); end
    tick();
    ncmp++; if (dp_rst !== 1'b0 || dp_en !== 1'b1) begin nerr++; $display("FAIL run_entry: dp_rst=%b dp_en=%b want 0/1", dp_rst, dp_en); end
    tick(); tick(); tick();
    ncmp++; if (cycle_count !== CW'(3)) begin nerr++; $display("FAIL run3_count: got %0d want 3", cycle_count); end
    ncmp++; if (branch_count !== CW'(m_br)) begin nerr++; $display("FAIL run3_branches: got %0d want %0d", branch_count, m_br); end
  endtask

  task automatic test_loop();
    int n = 0;
    int i = 0;
    loop_pcs = 1'b0;
    do_start(); tick(); tick();
    loop_pcs = 1'b1;
    while (!halted && i < 20) begin
      if (dp_en) n++;
      tick(); i++;
    end
    ncmp++; if (n != LOOPL || halted !== 1'b1) begin nerr++; $display("FAIL loop_cycles: got %0d en cycles halted=%b want %0d/1", n, halted, LOOPL); end
    ncmp++; if (halt_cause !== 3'd2 || dp_en !== 1'b0) begin nerr++; $display("FAIL loop_cause: cause=%0d dp_en=%b want 2/0", halt_cause, dp_en); end
  endtask

  task automatic test_ext_tie();
    loop_pcs = 1'b0;
    do_start(); tick(); tick();
    loop_pcs = 1'b1;
    tick(); tick(); tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    ncmp++; if (halted !== 1'b1 || halt_cause !== 3'd1) begin nerr++; $display("FAIL ext_over_loop: halted=%b cause=%0d want 1/1", halted, halt_cause); end
    ncmp++; if (cycle_count !== CW'(4)) begin nerr++; $display("FAIL ext_commit_counted: got %0d want 4", cycle_count); end
  endtask

  task automatic test_step();
    loop_pcs = 1'b0;
    halt_req = 1'b1; step = 1'b1; tick(); step = 1'b0;
    ncmp++; if (halted !== 1'b1 || dp_en !== 1'b0) begin nerr++; $display("FAIL step_blocked: halted=%b dp_en=%b want 1/0", halted, dp_en); end
    halt_req = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    ncmp++; if (state_o !== 3'd3 || dp_en !== 1'b1) begin nerr++; $display("FAIL step_enter: state=%0d dp_en=%b want 3/1", state_o, dp_en); end
    tick();
    ncmp++; if (halted !== 1'b1 || halt_cause !== 3'd4 || cycle_count !== CW'(5)) begin nerr++; $display("FAIL step_done: halted=%b cause=%0d count=%0d want 1/4/5", halted, halt_cause, cycle_count); end
    resume = 1'b1; tick(); resume = 1'b0;
    ncmp++; if (state_o !== 3'd2 || dp_rst !== 1'b0 || cycle_count !== CW'(5)) begin nerr++; $display("FAIL resume: state=%0d dp_rst=%b count=%0d want 2/0/5", state_o, dp_rst, cycle_count); end
    tick();
    ncmp++; if (dp_rst !== 1'b0 || dp_en !== 1'b1) begin nerr++; $display("FAIL resume_run: dp_rst=%b dp_en=%b want 0/1", dp_rst, dp_en); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int i = 0;
    loop_pcs = 1'b0;
    do_start(); tick(); tick();
    while (!halted && i < 40) begin
      if (dp_en) n++;
      tick(); i++;
    end
    ncmp++; if (n != MAXC || cycle_count !== CW'(MAXC)) begin nerr++; $display("FAIL timeout_cycles: en=%0d count=%0d want %0d", n, cycle_count, MAXC); end
    ncmp++; if (halted !== 1'b1 || halt_cause !== 3'd3) begin nerr++; $display("FAIL timeout_cause: halted=%b cause=%0d want 1/3", halted, halt_cause); end
  endtask

  task automatic test_saturate();
    loop_pcs = 1'b0;
    resume = 1'b1; tick(); resume = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    ncmp++; if (cycle_count !== CW'(CMAX) || dp_en !== 1'b1) begin nerr++; $display("FAIL saturate: count=%0d dp_en=%b want %0d/1", cycle_count, dp_en, CMAX); end
    ncmp++; if (branch_count !== CW'(m_br)) begin nerr++; $display("FAIL sat_branches: got %0d want %0d", branch_count, m_br); end
  endtask

  task automatic test_rst_mid();
    loop_pcs = 1'b0;
    do_start(); tick(); tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    ncmp++; if (state_o !== 3'd0 || {dp_rst, dp_en, halted, busy} !== 4'b0) begin nerr++; $display("FAIL rst_mid: state=%0d flags=%b want 0/0000", state_o, {dp_rst, dp_en, halted, busy}); end
    ncmp++; if ({cycle_count, branch_count, halt_cause} !== '0) begin nerr++; $display("FAIL rst_mid_counts: %0d/%0d/%0d want 0", cycle_count, branch_count, halt_cause); end
  endtask

  task automatic test_start_step();
    start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
    ncmp++; if (state_o !== 3'd1 || dp_rst !== 1'b1) begin nerr++; $display("FAIL start_beats_step: state=%0d dp_rst=%b want 1/1", state_o, dp_rst); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 39) == 0);
      step     = ($urandom_range(0, 9) == 0);
      resume   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      loop_pcs = ($urandom_range(0, 9) < 6);
      tick();
      ncmp++; if (state_o !== 3'(m_state)) begin nerr++; $display("FAIL rnd_state c=%0d: got %0d want %0d", c, state_o, m_state); end
      ncmp++; if (dp_rst !== (m_state == 1) || dp_en !== (m_state == 2 || m_state == 3)) begin nerr++; $display("FAIL rnd_ctrl c=%0d: rst/en=%b%b mode %0d", c, dp_rst, dp_en, m_state); end
      ncmp++; if (halted !== (m_state == 4) || busy !== (m_state >= 1 && m_state <= 3)) begin nerr++; $display("FAIL rnd_status c=%0d: halted/busy=%b%b mode %0d", c, halted, busy, m_state); end
      ncmp++; if (cycle_count !== CW'(m_cyc)) begin nerr++; $display("FAIL rnd_cycles c=%0d: got %0d want %0d", c, cycle_count, m_cyc); end
      ncmp++; if (branch_count !== CW'(m_br)) begin nerr++; $display("FAIL rnd_branches c=%0d: got %0d want %0d", c, branch_count, m_br); end
      if (m_state == 4 || m_state == 0) begin
        ncmp++; if (halt_cause !== 3'(m_cause)) begin nerr++; $display("FAIL rnd_cause c=%0d: got %0d want %0d", c, halt_cause, m_cause); end
      end
    end
    rst = 1'b0; start = 1'b0; step = 1'b0; resume = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_start_run();
    test_loop();
    test_ext_tie();
    test_step();
    test_timeout();
    test_saturate();
    test_rst_mid();
    test_start_step();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
